// File: rtl/core_pkg.sv
// Shared constants and types for the 64-bit pipelined core front end.
// Holds default widths, the reset PC, the bubble encoding and the IF/ID record.
package core_pkg;

    localparam int CORE_ADDR_W  = 64;
    localparam int CORE_INSTR_W = 32;
    localparam int CORE_CNT_W   = 32;

    localparam logic [CORE_ADDR_W-1:0]  CORE_RESET_PC = 64'h0;
    localparam logic [CORE_INSTR_W-1:0] NOP_INSTR     = 32'h0;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0]  pc;
        logic [CORE_INSTR_W-1:0] instr;
        logic                    valid;
    } ifid_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: hazard/branch control,
// instruction memory and the IF/ID pipeline outputs.
interface if_fetch_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
);
    logic               stall_i;
    logic               flush_i;
    logic               pc_src_i;
    logic [ADDR_W-1:0]  branch_target_i;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic [ADDR_W-1:0]  ifid_pc_o;
    logic [INSTR_W-1:0] ifid_instr_o;
    logic               ifid_valid_o;
    logic [CNT_W-1:0]   fetch_count_o;

    // master is the fetch stage itself; slave is the pipeline/memory side
    modport master (
        input  stall_i, flush_i, pc_src_i, branch_target_i, imem_rdata_i,
        output imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_count_o
    );

    modport slave (
        output stall_i, flush_i, pc_src_i, branch_target_i, imem_rdata_i,
        input  imem_addr_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, fetch_count_o
    );

endinterface

// File: rtl/mux32bit2_1.sv
// Generic 2:1 word multiplexer used for next-PC selection.
module mux32bit2_1 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1,
    input  logic             control,
    output logic [WIDTH-1:0] out
);

    assign out = control ? input1 : input0;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// a saturating count of instructions loaded into IF/ID.
module if_fetch_stage
    import core_pkg::*;
#(
    parameter int                ADDR_W   = CORE_ADDR_W,
    parameter int                INSTR_W  = CORE_INSTR_W,
    parameter int                CNT_W    = CORE_CNT_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CORE_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_stage_if.master bus
);

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  target_aligned;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  ifid_pc_q;
    logic [INSTR_W-1:0] ifid_instr_q;
    logic               ifid_valid_q;
    logic [CNT_W-1:0]   count_q;

    assign pc_plus4       = pc_q + ADDR_W'(4);
    assign target_aligned = bus.branch_target_i & ~ADDR_W'(3);

    mux32bit2_1 #(.WIDTH(ADDR_W)) u_next_pc (
        .input0  (pc_plus4),
        .input1  (target_aligned),
        .control (bus.pc_src_i),
        .out     (next_pc)
    );

    // A redirect must land even while the hazard unit is stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_PC;
        else if (bus.pc_src_i || !bus.stall_i)
            pc_q <= next_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= INSTR_W'(NOP_INSTR);
            ifid_valid_q <= 1'b0;
            count_q      <= '0;
        end else if (bus.flush_i) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= INSTR_W'(NOP_INSTR);
            ifid_valid_q <= 1'b0;
        end else if (!bus.stall_i) begin
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= bus.imem_rdata_i;
            ifid_valid_q <= 1'b1;
            if (count_q != '1)
                count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.imem_addr_o   = pc_q;
    assign bus.ifid_pc_o     = ifid_pc_q;
    assign bus.ifid_instr_o  = ifid_instr_q;
    assign bus.ifid_valid_o  = ifid_valid_q;
    assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table for the main pipeline, plus
// hand sequences for async reset and PC wrap / counter saturation.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(32)) bus_a ();
    if_fetch_stage_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(2))  bus_w ();

    if_fetch_stage #(.ADDR_W(64), .INSTR_W(32), .CNT_W(32), .RESET_PC(64'h1000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    if_fetch_stage #(.ADDR_W(64), .INSTR_W(32), .CNT_W(2), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w.master)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign bus_a.imem_rdata_i = instr_of(bus_a.imem_addr_o);
    assign bus_w.imem_rdata_i = instr_of(bus_w.imem_addr_o);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                         input logic e_v, input logic [31:0] e_cnt);
        chk({tag, " pc"},     bus_a.imem_addr_o, e_pc);
        chk({tag, " ifpc"},   bus_a.ifid_pc_o, e_ifpc);
        chk({tag, " instr"},  {32'h0, bus_a.ifid_instr_o}, e_v ? {32'h0, instr_of(e_ifpc)} : 64'h0);
        chk({tag, " valid"},  {63'h0, bus_a.ifid_valid_o}, {63'h0, e_v});
        chk({tag, " count"},  {32'h0, bus_a.fetch_count_o}, {32'h0, e_cnt});
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic        pc_src;
        logic [63:0] target;
        logic [63:0] e_pc;
        logic [63:0] e_ifpc;
        logic        e_v;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    logic [63:0] w_addr[5];
    logic [63:0] w_ifpc[5];
    logic [1:0]  w_cnt[5];

    initial begin
        // state after each clock edge
        vecs[0]  = '{0, 0, 0, 64'h0,    64'h1004, 64'h1000, 1, 1};
        vecs[1]  = '{0, 0, 0, 64'h0,    64'h1008, 64'h1004, 1, 2};
        vecs[2]  = '{1, 0, 0, 64'h0,    64'h1008, 64'h1004, 1, 2};
        vecs[3]  = '{1, 0, 0, 64'h0,    64'h1008, 64'h1004, 1, 2};
        vecs[4]  = '{0, 0, 0, 64'h0,    64'h100C, 64'h1008, 1, 3};
        vecs[5]  = '{0, 0, 0, 64'h0,    64'h1010, 64'h100C, 1, 4};
        vecs[6]  = '{0, 1, 1, 64'h2003, 64'h2000, 64'h0,    0, 4};
        vecs[7]  = '{0, 0, 0, 64'h0,    64'h2004, 64'h2000, 1, 5};
        vecs[8]  = '{1, 1, 1, 64'h3000, 64'h3000, 64'h0,    0, 5};
        vecs[9]  = '{0, 0, 0, 64'h0,    64'h3004, 64'h3000, 1, 6};
        vecs[10] = '{0, 0, 1, 64'h2012, 64'h2010, 64'h3004, 1, 7};
        vecs[11] = '{1, 1, 0, 64'h0,    64'h2010, 64'h0,    0, 7};

        w_addr = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8, 64'hC};
        w_ifpc = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8};
        w_cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst   = 1'b1;
        rst_w = 1'b1;
        bus_a.stall_i = 0; bus_a.flush_i = 0; bus_a.pc_src_i = 0; bus_a.branch_target_i = '0;
        bus_w.stall_i = 0; bus_w.flush_i = 0; bus_w.pc_src_i = 0; bus_w.branch_target_i = '0;

        @(negedge clk);
        chk_a("reset", 64'h1000, 64'h0, 1'b0, 32'd0);
        chk("wrap reset pc", bus_w.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFF8);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            bus_a.stall_i         = vecs[i].stall;
            bus_a.flush_i         = vecs[i].flush;
            bus_a.pc_src_i        = vecs[i].pc_src;
            bus_a.branch_target_i = vecs[i].target;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].e_v, vecs[i].e_cnt);
            @(negedge clk);
        end

        // async reset between edges must act before the next posedge
        bus_a.stall_i = 0; bus_a.flush_i = 0; bus_a.pc_src_i = 0; bus_a.branch_target_i = '0;
        chk("pre-reset pc", bus_a.imem_addr_o, 64'h2010);
        #2 rst = 1'b1;
        #1;
        chk_a("async rst", 64'h1000, 64'h0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_a("post rst", 64'h1004, 64'h1000, 1'b1, 32'd1);

        // wrap past the top of the address space; 2-bit count saturates at 3
        @(negedge clk);
        rst_w = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d pc", k),    bus_w.imem_addr_o, w_addr[k]);
            chk($sformatf("wrap%0d ifpc", k),  bus_w.ifid_pc_o, w_ifpc[k]);
            chk($sformatf("wrap%0d instr", k), {32'h0, bus_w.ifid_instr_o}, {32'h0, instr_of(w_ifpc[k])});
            chk($sformatf("wrap%0d count", k), {62'h0, bus_w.fetch_count_o}, {62'h0, w_cnt[k]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
